// File: rtl/axi_write_pkg.sv
// Shared definitions for the AXI write-data/write-response initiator.
//   RESP_*      : B-channel response encodings
//   wm_state_t  : control FSM states of axi_write_master
//   resp_is_err : classifies a B response as an error (SLVERR/DECERR)
package axi_write_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_SEND = 2'd1,
    B_WAIT = 2'd2
  } wm_state_t;

  function automatic logic resp_is_err(input logic [1:0] r);
    case (r)
      RESP_OKAY, RESP_EXOKAY:   return 1'b0;
      RESP_SLVERR, RESP_DECERR: return 1'b1;
      default:                  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axi_write_master_fifo.sv
// Small synchronous FIFO buffering user words ahead of the W channel.
//   clk, rstn : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i    : write data_i when not full
//   data_i    : word to store
//   pop_i     : discard the head entry when not empty
//   head_o    : oldest stored word, read straight from the storage registers
//   full_o    : no free entry
//   empty_o   : no stored entry
module axi_wr_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits coincide.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; a flush only needs the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/axi_write_master.sv
// AXI4 W/B-channel write initiator. User words are queued in a FIFO, each
// sent as a single W beat, and the B response is awaited before the next.
//   clk, rstn          : clock, asynchronous active-low reset
//   usr_data/valid     : producer word and push request
//   usr_ready          : FIFO not full
//   wdata/wvalid/wready: W channel
//   bresp/bvalid/bready: B channel
//   done / err         : one-cycle completion / error (or timeout) pulses
//   last_resp          : response of the last completed transfer
//   timeout            : sticky, cleared by the next OKAY/EXOKAY response
//   err_cnt            : saturating count of err pulses
//   busy               : transfer in flight or words queued
module axi_write_master
  import axi_write_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] usr_data,
  input  logic              usr_valid,
  output logic              usr_ready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              done,
  output logic              err,
  output logic [1:0]        last_resp,
  output logic              timeout,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value on which the final silent B_WAIT cycle is spent.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  wm_state_t         state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        last_resp_q, last_resp_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  axi_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (usr_valid),
    .data_i  (usr_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign usr_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign last_resp = last_resp_q;
  assign timeout   = timeout_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    last_resp_d = last_resp_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    to_cnt_d    = to_cnt_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          wdata_d  = fifo_head;
          wvalid_d = 1'b1;
          state_d  = W_SEND;
        end
      end

      W_SEND: begin
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          bready_d = 1'b1;
          to_cnt_d = '0;
          state_d  = B_WAIT;
        end
      end

      B_WAIT: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          last_resp_d = bresp;
          if (resp_is_err(bresp)) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc8(err_cnt_q);
          end else begin
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          // Silent slave: give up after TIMEOUT cycles and drop the word.
          if (to_cnt_q == TO_LAST) begin
            bready_d  = 1'b0;
            err_d     = 1'b1;
            timeout_d = 1'b1;
            err_cnt_d = sat_inc8(err_cnt_q);
            state_d   = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_resp_q <= RESP_OKAY;
      timeout_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_resp_q <= last_resp_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
module tb_axi_write_master;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] usr_data = '0;
  logic              usr_valid = 1'b0;
  logic              usr_ready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready = 1'b0;
  logic [1:0]        bresp = 2'b00;
  logic              bvalid = 1'b0;
  logic              bready;
  logic              done;
  logic              err;
  logic [1:0]        last_resp;
  logic              timeout;
  logic [7:0]        err_cnt;
  logic              busy;

  always #5 clk = ~clk;

  axi_write_master #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .usr_data  (usr_data),
    .usr_valid (usr_valid),
    .usr_ready (usr_ready),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .done      (done),
    .err       (err),
    .last_resp (last_resp),
    .timeout   (timeout),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a queue of words and one "where is the
  // current word" phase (0 none, 1 offered on W, 2 awaiting B).
  logic [31:0] mq[$];
  int          m_phase   = 0;
  logic [31:0] m_wdata   = '0;
  logic        m_wvalid  = 1'b0;
  logic        m_bready  = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_err     = 1'b0;
  logic [1:0]  m_last    = 2'b00;
  logic        m_timeout = 1'b0;
  int          m_errcnt  = 0;
  int          m_waited  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        mq.delete();
        m_phase = 0; m_wdata = '0; m_wvalid = 0; m_bready = 0;
        m_done = 0; m_err = 0; m_last = 2'b00; m_timeout = 0;
        m_errcnt = 0; m_waited = 0;
      end else begin
        bit accept;
        accept = usr_valid && (mq.size() < DEPTH);
        m_done = 0;
        m_err  = 0;
        if (m_phase == 0) begin
          if (mq.size() != 0) begin
            m_wdata  = mq.pop_front();
            m_wvalid = 1;
            m_phase  = 1;
          end
        end else if (m_phase == 1) begin
          if (wready) begin
            m_wvalid = 0;
            m_bready = 1;
            m_waited = 0;
            m_phase  = 2;
          end
        end else begin
          if (bvalid) begin
            m_bready = 0;
            m_last   = bresp;
            if (bresp[1]) begin
              m_err = 1;
              if (m_errcnt < 255) m_errcnt++;
            end else begin
              m_done    = 1;
              m_timeout = 0;
            end
            m_phase = 0;
          end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
              m_err     = 1;
              m_timeout = 1;
              if (m_errcnt < 255) m_errcnt++;
              m_bready  = 0;
              m_phase   = 0;
            end
          end
        end
        if (accept) mq.push_back(usr_data);
      end
    end
  end

  // Cycle-by-cycle comparison against the reference, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("usr_ready", {31'd0, usr_ready}, {31'd0, mq.size() < DEPTH});
      chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0) || (mq.size() != 0)});
      chk("wvalid", {31'd0, wvalid}, {31'd0, m_wvalid});
      if (m_wvalid) chk("wdata", wdata, m_wdata);
      chk("bready", {31'd0, bready}, {31'd0, m_bready});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("last_resp", {30'd0, last_resp}, {30'd0, m_last});
      chk("timeout", {31'd0, timeout}, {31'd0, m_timeout});
      chk("err_cnt", {24'd0, err_cnt}, m_errcnt[31:0]);
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_wvalid"}, {31'd0, wvalid}, 32'd0);
    chk({tag, "_bready"}, {31'd0, bready}, 32'd0);
    chk({tag, "_done_err"}, {30'd0, done, err}, 32'd0);
    chk({tag, "_last_resp"}, {30'd0, last_resp}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_usr_ready"}, {31'd0, usr_ready}, 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_values(tag);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the word was taken.
  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    usr_valid = 1'b1;
    usr_data  = d;
    while (!usr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", {31'd0, usr_ready}, 32'd1);
    @(negedge clk);
    usr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          cnt_wv, cnt_done, cnt_err, acc, n;
    logic [31:0] seen;
    logic [31:0] words[6];
    logic [31:0] sent[$];

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_values("por");
    #2 rstn = 1'b1;
    @(negedge clk);

    // Single word, zero-wait slave, OKAY
    wready = 1; bvalid = 1; bresp = 2'b00;
    push(32'hDEADBEEF);
    cnt_wv = 0; cnt_done = 0; seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (wvalid) begin cnt_wv++; seen = wdata; end
      if (done) cnt_done++;
      @(negedge clk);
    end
    chk("t1_wvalid_cycles", cnt_wv, 1);
    chk("t1_wdata", seen, 32'hDEADBEEF);
    chk("t1_done_pulses", cnt_done, 1);
    chk("t1_last_resp", {30'd0, last_resp}, 32'd0);
    chk("t1_err_cnt", {24'd0, err_cnt}, 32'd0);

    // FIFO fill behind a word already stalled on W: four more fit, fifth stalls
    wready = 0; bvalid = 0;
    words = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002,
              32'h1111_0003, 32'h1111_0004, 32'h1111_0005};
    push(words[0]);
    @(negedge clk);
    acc = 1;
    for (int c = 0; c < 8; c++) begin
      usr_valid = 1'b1;
      usr_data  = words[acc];
      if (usr_ready && acc < 6) acc++;
      @(negedge clk);
    end
    chk("t2_accepted_before_stall", acc - 1, 4);
    chk("t2_usr_ready_low", {31'd0, usr_ready}, 32'd0);
    wready = 1; bvalid = 1; bresp = 2'b00;
    sent.delete();
    for (int c = 0; c < 60 && sent.size() < 6; c++) begin
      if (wvalid && wready) sent.push_back(wdata);
      if (acc < 6) begin
        usr_valid = 1'b1;
        usr_data  = words[acc];
        if (usr_ready) acc++;
      end else begin
        usr_valid = 1'b0;
      end
      @(negedge clk);
    end
    usr_valid = 1'b0;
    chk("t2_sent_count", sent.size(), 6);
    for (int i = 0; i < 6 && i < sent.size(); i++) chk("t2_order", sent[i], words[i]);
    wait_idle("t2");

    // wready delayed three cycles: beat held stable for four cycles
    wready = 0; bvalid = 0;
    push(32'hA5A5_0003);
    n = 0;
    while (!wvalid && n < 10) begin @(negedge clk); n++; end
    chk("t3_wvalid_seen", {31'd0, wvalid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_wvalid_held", {31'd0, wvalid}, 32'd1);
      chk("t3_wdata_held", wdata, 32'hA5A5_0003);
      if (i == 3) wready = 1;
      @(negedge clk);
    end
    wready = 0;
    chk("t3_wvalid_dropped", {31'd0, wvalid}, 32'd0);
    chk("t3_bready", {31'd0, bready}, 32'd1);
    bvalid = 1; bresp = 2'b01;
    @(negedge clk);
    bvalid = 0;
    chk("t3_done_exokay", {31'd0, done}, 32'd1);
    chk("t3_last_resp", {30'd0, last_resp}, 32'd1);

    // SLVERR then DECERR
    do_reset("rst_a");
    wready = 1; bvalid = 1; bresp = 2'b10;
    push(32'h0000_E001);
    push(32'h0000_E002);
    cnt_err = 0; cnt_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (err) begin cnt_err++; bresp = 2'b11; end
      if (done) cnt_done++;
      @(negedge clk);
    end
    chk("t4_err_pulses", cnt_err, 2);
    chk("t4_done_pulses", cnt_done, 0);
    chk("t4_err_cnt", {24'd0, err_cnt}, 32'd2);
    chk("t4_last_resp", {30'd0, last_resp}, 32'd3);

    // Timeout after TIMEOUT silent B_WAIT cycles, stray bvalid ignored
    bvalid = 0; bresp = 2'b00; wready = 1;
    push(32'h0000_7707);
    n = 0;
    while (!bready && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (bready && n < 20) begin @(negedge clk); n++; end
    chk("t5_bready_cycles", n, TIMEOUT);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_timeout", {31'd0, timeout}, 32'd1);
    chk("t5_err_cnt", {24'd0, err_cnt}, 32'd3);
    chk("t5_last_resp_kept", {30'd0, last_resp}, 32'd3);
    bvalid = 1; bresp = 2'b10;
    repeat (2) @(negedge clk);
    bvalid = 0;
    chk("t5_stray_ignored", {24'd0, err_cnt}, 32'd3);
    bresp = 2'b00;
    push(32'h0000_0C0C);
    bvalid = 1;
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_timeout_cleared", {31'd0, timeout}, 32'd0);
    chk("t5_last_resp_okay", {30'd0, last_resp}, 32'd0);
    bvalid = 0;
    @(negedge clk);

    // Reset during B_WAIT with three words queued
    wready = 1; bvalid = 0;
    for (int i = 0; i < 4; i++) push(32'hBB00_0000 + i);
    chk("t6_in_b_wait", {31'd0, bready}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    do_reset("rst_mid");
    bvalid = 1;
    cnt_wv = 0;
    for (int i = 0; i < 10; i++) begin
      if (wvalid) cnt_wv++;
      @(negedge clk);
    end
    chk("t6_nothing_sent", cnt_wv, 0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    // Error counter saturation
    wready = 1; bvalid = 1; bresp = 2'b10; usr_valid = 1;
    for (int i = 0; i < 1200; i++) begin
      usr_data = $urandom;
      @(negedge clk);
    end
    usr_valid = 0;
    chk("t7_err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
    wait_idle("t7");
    do_reset("rst_b");

    // Randomized traffic with varying slave behaviour
    for (int seg = 0; seg < 6; seg++) begin
      int pv, pw, pb;
      pv = $urandom_range(1, 4);
      pw = $urandom_range(1, 4);
      pb = $urandom_range(2, 10);
      for (int i = 0; i < 500; i++) begin
        usr_valid = ($urandom_range(0, pv) != 0);
        usr_data  = $urandom;
        wready    = ($urandom_range(0, pw) != 0);
        bvalid    = ($urandom_range(0, pb - 1) == 0);
        bresp     = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
    end
    usr_valid = 0; wready = 1; bvalid = 1; bresp = 2'b00;
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
